// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the frame router and its 1-to-8 demux.
package demux_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, STOP} frame_state_t;
  localparam int DEMUX_SEL_W = 3;
  localparam int DEMUX_CH = 8;
endpackage

// File: rtl/demux_frame_router.sv
// demux_frame_router: parses start/addr/payload/stop serial frames into demux sel and in.
module demux_frame_router
  import demux_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic                   rx_bit,
  output logic [DEMUX_SEL_W-1:0] sel,
  output logic                   dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);
  localparam int CW = PAYLOAD_LEN > 1 ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_LEN - 1);
  frame_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] acnt_q, acnt_d;
  logic [DEMUX_SEL_W-1:0] addr_q, addr_d, sel_q, sel_d;
  logic dout_q, dout_d, dv_q, dv_d, done_q, done_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acnt_d = acnt_q;
    addr_d = addr_q;
    sel_d = sel_q;
    dout_d = 1'b0;
    dv_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          state_d = rx_bit ? ADDR : IDLE;
          acnt_d = '0;
        end
        ADDR: begin
          addr_d = {addr_q[1:0], rx_bit};
          acnt_d = acnt_q + 2'd1;
          if (acnt_q == 2'd2) begin
            sel_d = {addr_q[1:0], rx_bit};
            state_d = DATA;
            cnt_d = '0;
          end
        end
        DATA: begin
          dout_d = rx_bit;
          dv_d = 1'b1;
          // hold at terminal rather than wrapping; cleared again on the next DATA entry
          cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
          state_d = cnt_q == LAST ? STOP : DATA;
        end
        default: begin
          done_d = ~rx_bit;
          err_d = rx_bit;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acnt_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      dout_q <= 1'b0;
      dv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acnt_q <= acnt_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      dout_q <= dout_d;
      dv_q <= dv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign sel = sel_q;
  assign dout = dout_q;
  assign dout_valid = dv_q;
  assign busy = state_q != IDLE;
  assign frame_done = done_q;
  assign frame_err = err_q;
endmodule

// File: doc/demux_frame_router.md
# demux_frame_router

Serial frame parser that sits directly upstream of the 1-to-8 demultiplexer and produces its `in` and `sel` inputs. It receives a bit stream of framed packets (start bit, 3-bit channel address, fixed-length payload, stop bit). It registers the address onto `sel` and streams each payload bit onto `dout`, with a per-bit valid strobe. `sel` is held stable for the whole payload, so the demux routes the complete payload to a single output channel.

## Interface
- `PAYLOAD_LEN`, 8: payload bits per frame; legal range 1..256.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous reset, active-high.
- `rx_valid` input 1: `rx_bit` is valid this cycle; cycles with `rx_valid`=0 are ignored (stall).
- `rx_bit` input 1: serial data bit.
- `sel` output 3: channel select to the demux; registered; reset 3'b000.
- `dout` output 1: payload bit to the demux `in`; registered; forced 0 when `dout_valid`=0; reset 0.
- `dout_valid` output 1: one-cycle strobe per payload bit; reset 0.
- `busy` output 1: high in every state except IDLE; reset 0.
- `frame_done` output 1: one-cycle pulse when a stop bit of 0 is accepted; reset 0.
- `frame_err` output 1: one-cycle pulse when a stop bit of 1 is accepted; reset 0.

## Operation
- Accepted bit: a cycle in which `rx_valid`=1. All FSM progress occurs only on accepted bits.
- FSM states and transitions:
  - IDLE → ADDR on an accepted bit of 1 (start). An accepted 0 in IDLE is discarded.
  - ADDR takes 3 accepted bits, MSB first, into an address shift register. The 3rd bit moves the FSM to DATA.
  - DATA takes PAYLOAD_LEN accepted bits. The last one moves the FSM to STOP.
  - STOP takes one accepted bit. A 0 pulses `frame_done`; a 1 pulses `frame_err`. Either way the FSM returns to IDLE.
- `sel` loads the full 3-bit address once, on acceptance of the 3rd address bit.
  - Otherwise `sel` holds its value, including through IDLE, STOP and error frames, until the next frame's address completes.
- Payload bit count:
  - Counter width is $clog2(PAYLOAD_LEN), with a minimum of 1 bit.
  - The counter clears on entry to DATA.
  - Terminal value is PAYLOAD_LEN-1.
  - The counter never wraps within a frame.
- No back-pressure exists: the downstream demux is combinational and always accepts.
- Reset in any state, including mid-payload:
  - FSM returns to IDLE; counters and shift register clear.
  - All outputs take their reset values on the next edge.
  - Any partial frame is abandoned without a `frame_err` pulse.
- A start bit arriving while the STOP bit is being accepted is impossible, since only one bit is accepted per cycle. A new start is recognised no earlier than the cycle after the return to IDLE.

## Timing
- Payload bit accepted at edge n: `dout`/`dout_valid` are valid in cycle n+1 (1-cycle latency).
- 3rd address bit accepted at edge n: new `sel` is valid in cycle n+1, which is no later than the first `dout_valid`.
- `frame_done`/`frame_err` are asserted in the cycle after the stop bit is accepted, for exactly one cycle.
- `busy` rises the cycle after the start bit is accepted. It falls the cycle after the stop bit is accepted.
- Minimum frame length with continuous `rx_valid` is PAYLOAD_LEN+5 cycles. Back-to-back frames are supported with 0 idle cycles.
- A stall (`rx_valid`=0) inserts a gap in `dout_valid`. `sel`, FSM state and counters hold.

## Structure
- Shared package `demux_pkg`:
  - state enum `frame_state_t` {IDLE, ADDR, DATA, STOP};
  - `DEMUX_SEL_W` = 3;
  - `DEMUX_CH` = 8.
- Single module; no sub-module needed. The payload bit counter and the address shift register live inline.
- Parent level connects `sel` → demux `sel`, and `dout` → demux `in`.

## Test plan
- PAYLOAD_LEN=8, continuous valid; stream 1 | 1,0,1 | 1,0,1,1,0,0,1,0 | 0.
  - `sel`=3'b101 appears one cycle after the 3rd address bit.
  - 8 consecutive `dout_valid` strobes with `dout`=1,0,1,1,0,0,1,0.
  - `frame_done` pulses once; `busy` is low afterwards.
- Same frame with `rx_valid` dropped for 3 cycles between payload bits 4 and 5.
  - `dout_valid` shows a 3-cycle gap; `sel` stays 5; `dout` sequence is unchanged.
- Frame to address 3'b010 with stop bit 1.
  - `frame_err` pulses once and `frame_done` stays 0.
  - `sel` remains 2 until the next frame's address completes.
- Reset asserted after payload bit 3.
  - Next cycle: `busy`=0, `sel`=0, `dout_valid`=0, no error pulse.
  - A following full frame to address 7 routes correctly.
- PAYLOAD_LEN=1, two back-to-back frames (addr 0 payload 1, then addr 7 payload 1).
  - `sel` goes 0 then 7.
  - Two `dout_valid` strobes, each with `dout`=1.
  - Two `frame_done` pulses, 6 cycles apart.
- Leading zeros in IDLE (0,0,0 then a valid frame).
  - The zeros are discarded; `busy` stays 0 until the start bit.
